// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown timer: FSM states, BCD count
// layout, seven-segment encoding and BCD digit clamping.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Count held as three BCD digits, displayed as SS.t
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] tenths;
  } bcd_count_t;

  // Active-low segments {dp,g,f,e,d,c,b,a}; all ones is a dark digit
  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  // AND mask that lights the decimal point after the ones digit
  localparam logic [7:0] SEG_DP_MASK = 8'h7F;

  // Digit 0-9 to active-low segment code; anything else is dark
  function automatic logic [7:0] seg7(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Switch nibbles above 9 are not valid BCD; treat them as 9
  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > 4'd9) ? 4'd9 : nibble;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-key conditioner: two-flop synchroniser, level debounce and a
// single-cycle pulse on each accepted press (high-to-low of the active-low key).
module key_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  // Counter value at which the DEB_CYCLES-th differing sample is seen
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Bring the asynchronous key into the clock domain; idle is released (1)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed from the accepted level for
  // DEB_CYCLES consecutive samples; any agreeing sample restarts the count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: BCD preset 00-99 s from switches, 0.1 s
// countdown, start/pause and clear keys, SS.t on three seven-segment digits.
module countdown_timer_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV   = 5_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic [7:0] preset,
  output logic [7:0] hex2,
  output logic [7:0] hex1,
  output logic [7:0] hex0,
  output logic       led_run,
  output logic       led_done,
  output logic       done_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          w_start;
  logic          w_clear;
  logic          w_tick;
  logic          w_count_zero;
  logic          w_dec_zero;
  state_e        r_state;
  state_e        w_state_nxt;
  bcd_count_t    r_count;
  bcd_count_t    w_count_nxt;
  bcd_count_t    w_count_dec;
  bcd_count_t    w_count_preset;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_hex2;
  logic [7:0]    r_hex1;
  logic [7:0]    r_hex0;
  logic          r_led_run;
  logic          r_led_done;
  logic          r_done_pulse;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_key_n (key_start_n),
    .o_press (w_start)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_key_n (key_clear_n),
    .o_press (w_clear)
  );

  assign w_count_preset = {bcd_clamp(preset[7:4]), bcd_clamp(preset[3:0]), 4'd0};
  assign w_count_zero   = (r_count == '0);
  assign w_dec_zero     = (w_count_dec == '0);
  assign w_tick         = (r_state == RUN) && (r_presc == PRESC_LAST);

  // Prescaler runs only in RUN so each RUN entry begins a full tick period
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
    end else if (r_state == RUN) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end else begin
      r_presc <= '0;
    end
  end

  // BCD decrement by one tenth with borrows; holds at 00.0 so it never wraps
  always_comb begin
    w_count_dec = r_count;
    if (!w_count_zero) begin
      if (r_count.tenths != 4'd0) begin
        w_count_dec.tenths = r_count.tenths - 4'd1;
      end else begin
        w_count_dec.tenths = 4'd9;
        if (r_count.ones != 4'd0) begin
          w_count_dec.ones = r_count.ones - 4'd1;
        end else begin
          w_count_dec.ones = 4'd9;
          w_count_dec.tens = r_count.tens - 4'd1;
        end
      end
    end
  end

  // Next state and next count; clear outranks every other event
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        w_count_nxt = w_count_preset;
        if (w_clear)      w_state_nxt = IDLE;
        else if (w_start) w_state_nxt = w_count_zero ? DONE : RUN;
      end
      RUN: begin
        if (w_clear) begin
          w_state_nxt = IDLE;
        end else begin
          if (w_tick) w_count_nxt = w_count_dec;
          // A tick reaching zero wins over a simultaneous pause request
          if (w_tick && w_dec_zero) w_state_nxt = DONE;
          else if (w_start)         w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (w_clear)      w_state_nxt = IDLE;
        else if (w_start) w_state_nxt = RUN;
      end
      DONE: begin
        w_count_nxt = '0;
        if (w_clear || w_start) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and count registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Registered display/LEDs trail state and count by one cycle; done_pulse is
  // taken from the transition so it coincides with the first DONE cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hex2       <= SEG_BLANK;
      r_hex1       <= SEG_BLANK;
      r_hex0       <= SEG_BLANK;
      r_led_run    <= 1'b0;
      r_led_done   <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_hex2       <= seg7(r_count.tens);
      r_hex1       <= seg7(r_count.ones) & SEG_DP_MASK;
      r_hex0       <= seg7(r_count.tenths);
      r_led_run    <= (r_state == RUN);
      r_led_done   <= (r_state == DONE);
      r_done_pulse <= (w_state_nxt == DONE) && (r_state != DONE);
    end
  end

  assign hex2       = r_hex2;
  assign hex1       = r_hex1;
  assign hex0       = r_hex0;
  assign led_run    = r_led_run;
  assign led_done   = r_led_done;
  assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with a short tick and debounce.
// All stimulus is driven and all outputs sampled on the falling clock edge.
// A key held low for 6 falling edges is acted on by the FSM at the 6th rising
// edge; a tick then lands every 4th rising edge after RUN entry.
module tb_countdown_timer_ctrl;

  logic       CLK;
  logic       RST;
  logic       key_start_n;
  logic       key_clear_n;
  logic [7:0] preset;
  logic [7:0] hex2;
  logic [7:0] hex1;
  logic [7:0] hex0;
  logic       led_run;
  logic       led_done;
  logic       done_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .preset      (preset),
    .hex2        (hex2),
    .hex1        (hex1),
    .hex0        (hex0),
    .led_run     (led_run),
    .led_done    (led_done),
    .done_pulse  (done_pulse)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [7:0] e2, input logic [7:0] e1,
                           input logic [7:0] e0);
    check({tag, "_hex2"}, hex2, e2);
    check({tag, "_hex1"}, hex1, e1);
    check({tag, "_hex0"}, hex0, e0);
  endtask

  // Hold a key low long enough to be accepted; returns right after the FSM acts
  task automatic press_key(input bit use_clear);
    if (use_clear) key_clear_n = 1'b0;
    else           key_start_n = 1'b0;
    repeat (6) @(negedge CLK);
    key_clear_n = 1'b1;
    key_start_n = 1'b1;
  endtask

  initial begin
    RST         = 1'b1;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    preset      = 8'h12;

    // 1: reset values, then preset 12 shown two cycles after release
    repeat (3) @(negedge CLK);
    check_hex("rst", 8'hFF, 8'hFF, 8'hFF);
    check("rst_led_run", {7'b0, led_run}, 8'h00);
    check("rst_led_done", {7'b0, led_done}, 8'h00);
    check("rst_done_pulse", {7'b0, done_pulse}, 8'h00);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_hex("idle_12", 8'hF9, 8'h24, 8'hC0);

    // 2: preset 01.0 counts to 00.0 in 10 ticks
    preset = 8'h01;
    repeat (2) @(negedge CLK);
    check_hex("idle_01", 8'hC0, 8'h79, 8'hC0);
    press_key(1'b0);
    @(negedge CLK);
    check("run1_led_run", {7'b0, led_run}, 8'h01);
    repeat (38) @(negedge CLK);
    check("pre_done_pulse", {7'b0, done_pulse}, 8'h00);
    @(negedge CLK);
    check("done_pulse_hi", {7'b0, done_pulse}, 8'h01);
    @(negedge CLK);
    check("done_pulse_lo", {7'b0, done_pulse}, 8'h00);
    check("done_led_done", {7'b0, led_done}, 8'h01);
    check("done_led_run", {7'b0, led_run}, 8'h00);
    check_hex("done_00", 8'hC0, 8'h40, 8'hC0);

    // 3: clamped preset 59.0, pause at 58.7, resume
    preset = 8'h5A;
    repeat (5) @(negedge CLK);
    press_key(1'b0);
    repeat (2) @(negedge CLK);
    check_hex("idle_59", 8'h92, 8'h10, 8'hC0);
    repeat (4) @(negedge CLK);
    press_key(1'b0);
    repeat (8) @(negedge CLK);
    press_key(1'b0);
    repeat (3) @(negedge CLK);
    check_hex("pause_587", 8'h92, 8'h00, 8'hF8);
    check("pause_led_run", {7'b0, led_run}, 8'h00);
    repeat (8) @(negedge CLK);
    check("pause_frozen_hex0", hex0, 8'hF8);
    press_key(1'b0);
    repeat (5) @(negedge CLK);
    check("resume_hex0", hex0, 8'h82);
    check("resume_led_run", {7'b0, led_run}, 8'h01);

    // 5a: clear during RUN returns to IDLE showing the preset
    preset = 8'h37;
    press_key(1'b1);
    repeat (2) @(negedge CLK);
    check_hex("clear_37", 8'hB0, 8'h78, 8'hC0);
    check("clear_led_run", {7'b0, led_run}, 8'h00);

    // 4: preset 00 goes straight to DONE
    preset = 8'h00;
    repeat (6) @(negedge CLK);
    press_key(1'b0);
    check("zero_done_pulse", {7'b0, done_pulse}, 8'h01);
    @(negedge CLK);
    check("zero_pulse_lo", {7'b0, done_pulse}, 8'h00);
    check("zero_led_done", {7'b0, led_done}, 8'h01);
    check("zero_led_run", {7'b0, led_run}, 8'h00);
    check_hex("zero_00", 8'hC0, 8'h40, 8'hC0);
    repeat (5) @(negedge CLK);
    press_key(1'b0);
    @(negedge CLK);
    check("done_to_idle_led_done", {7'b0, led_done}, 8'h00);

    // 5b: reset in the middle of a run
    preset = 8'h37;
    repeat (6) @(negedge CLK);
    press_key(1'b0);
    repeat (6) @(negedge CLK);
    check("mid_run_hex0", hex0, 8'h90);
    check("mid_run_led_run", {7'b0, led_run}, 8'h01);
    RST = 1'b1;
    #2;
    check_hex("async_rst", 8'hFF, 8'hFF, 8'hFF);
    check("async_rst_led_run", {7'b0, led_run}, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check_hex("after_rst_37", 8'hB0, 8'h78, 8'hC0);

    // 6a: two-cycle glitch on the start key is rejected
    key_start_n = 1'b0;
    repeat (2) @(negedge CLK);
    key_start_n = 1'b1;
    repeat (10) @(negedge CLK);
    check("glitch_led_run", {7'b0, led_run}, 8'h00);
    check("glitch_hex0", hex0, 8'hC0);

    // 6b: start press lands on the same cycle as the 3rd tick
    press_key(1'b0);
    repeat (6) @(negedge CLK);
    press_key(1'b0);
    repeat (3) @(negedge CLK);
    check_hex("tick_start_367", 8'hB0, 8'h02, 8'hF8);
    check("tick_start_led_run", {7'b0, led_run}, 8'h00);
    repeat (8) @(negedge CLK);
    check("tick_start_frozen", hex0, 8'hF8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
